// File: rtl/audio_rd_sched.sv
// Read-side scheduler: presents one FIFO frame to all participating consumers and advances once all are done.
// Optional consumer timeout path is built when AUDIO_RD_SCHED_TIMEOUT_EN is defined.
module audio_rd_sched #(
    parameter int unsigned NUM_CONSUMERS  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SEQ_W          = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic [NUM_CONSUMERS-1:0] consumer_mask,
    input  logic                     clear_status,
    input  logic                     buffer_ready,
    input  logic                     buffer_full,
    output logic                     adv_read_enable,
    output logic [NUM_CONSUMERS-1:0] frame_valid,
    input  logic [NUM_CONSUMERS-1:0] frame_done,
    output logic [SEQ_W-1:0]         frame_seq,
    output logic [CNT_W-1:0]         overrun_count,
    output logic [NUM_CONSUMERS-1:0] timeout_consumer,
    output logic                     timeout_pulse,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ADV    = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [NUM_CONSUMERS-1:0] pending_q, pending_d;
    logic [NUM_CONSUMERS-1:0] pending_next;
    logic                     seen_q, seen_d;
    logic                     timeout_hit;
    logic                     ovr_inc;
    logic                     adv_q, adv_d;
    logic [NUM_CONSUMERS-1:0] fv_q, fv_d;
    logic [SEQ_W-1:0]         seq_q, seq_d;
    logic [CNT_W-1:0]         ovr_q, ovr_d, ovr_base;
    logic [NUM_CONSUMERS-1:0] tc_q, tc_d, tc_base;
    logic                     tp_q, tp_d;
    logic                     busy_q, busy_d;

`ifdef AUDIO_RD_SCHED_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    // Timer counts WAIT cycles of the current frame; the last allowed cycle is TIMEOUT_CYCLES-1.
    always_comb begin
        timer_d     = timer_q;
        timeout_hit = 1'b0;
        if (state_q == S_IDLE) begin
            timer_d = '0;
        end else if (state_q == S_WAIT) begin
            timer_d     = timer_q + TMR_W'(1);
            timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) && (pending_next != '0);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign pending_next = pending_q & ~frame_done;

    // Next state plus registered-output next values.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        seen_d    = seen_q;
        ovr_inc   = 1'b0;
        tp_d      = 1'b0;
        tc_base   = clear_status ? '0 : tc_q;
        tc_d      = tc_base;
        ovr_base  = clear_status ? '0 : ovr_q;
        ovr_d     = ovr_base;

        case (state_q)
            S_IDLE: begin
                if (enable && buffer_ready && (consumer_mask != '0)) begin
                    state_d   = S_WAIT;
                    pending_d = consumer_mask;
                    seen_d    = 1'b0;
                end
            end
            S_WAIT: begin
                seen_d    = seen_q | buffer_full;
                pending_d = pending_next;
                if (pending_next == '0) begin
                    state_d = S_ADV;
                end else if (timeout_hit) begin
                    state_d = S_ADV;
                    tp_d    = 1'b1;
                    tc_d    = tc_base | pending_next;
                end
            end
            S_ADV: begin
                ovr_inc = seen_q | buffer_full;
                state_d = S_SETTLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ovr_inc && (ovr_base != {CNT_W{1'b1}})) begin
            ovr_d = ovr_base + CNT_W'(1);
        end

        adv_d  = (state_d == S_ADV);
        seq_d  = adv_d ? seq_q + SEQ_W'(1) : seq_q;
        fv_d   = (state_d == S_WAIT) ? pending_d : '0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            seen_q    <= 1'b0;
            adv_q     <= 1'b0;
            fv_q      <= '0;
            seq_q     <= '0;
            ovr_q     <= '0;
            tc_q      <= '0;
            tp_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            seen_q    <= seen_d;
            adv_q     <= adv_d;
            fv_q      <= fv_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            tc_q      <= tc_d;
            tp_q      <= tp_d;
            busy_q    <= busy_d;
        end
    end

    assign adv_read_enable  = adv_q;
    assign frame_valid      = fv_q;
    assign frame_seq        = seq_q;
    assign overrun_count    = ovr_q;
    assign timeout_consumer = tc_q;
    assign timeout_pulse    = tp_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_audio_rd_sched.sv
// Bench for audio_rd_sched: frame-level reference model checked every cycle plus directed literal checks.
module tb_audio_rd_sched;

`ifdef AUDIO_RD_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] mask = '0;
    logic       clear = 1'b0;
    logic       ready = 1'b0;
    logic       full = 1'b0;
    logic       adv;
    logic [3:0] fv;
    logic [3:0] done = '0;
    logic [3:0] seq;
    logic [1:0] ovr;
    logic [3:0] tc;
    logic       tp;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    audio_rd_sched #(
        .NUM_CONSUMERS (4),
        .TIMEOUT_CYCLES(TO_CYC),
        .SEQ_W         (4),
        .CNT_W         (2)
    ) dut (
        .sys_clk         (clk),
        .sys_rst_n       (rst_n),
        .enable          (enable),
        .consumer_mask   (mask),
        .clear_status    (clear),
        .buffer_ready    (ready),
        .buffer_full     (full),
        .adv_read_enable (adv),
        .frame_valid     (fv),
        .frame_done      (done),
        .frame_seq       (seq),
        .overrun_count   (ovr),
        .timeout_consumer(tc),
        .timeout_pulse   (tp),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: phase 0 idle, 1 presenting, 2 advance, 3 settle.
    int         m_phase = 0;
    int         m_wait_cycles = 0;
    bit         m_seen = 1'b0;
    logic [3:0] m_pend = '0;
    logic       e_adv = 1'b0, e_tp = 1'b0, e_busy = 1'b0;
    logic [3:0] e_fv = '0, e_tc = '0;
    int         e_seq = 0, e_ovr = 0;

    always @(posedge clk) begin
        logic [3:0] left;
        logic [3:0] tc_ev;
        int         inc;
        int         nph;
        if (!rst_n) begin
            m_phase = 0; m_wait_cycles = 0; m_seen = 1'b0; m_pend = '0;
            e_adv = 1'b0; e_tp = 1'b0; e_busy = 1'b0; e_fv = '0; e_tc = '0;
            e_seq = 0; e_ovr = 0;
        end else begin
            tc_ev = '0; inc = 0; nph = m_phase; e_tp = 1'b0;
            case (m_phase)
                0: if (enable && ready && mask != 4'b0) begin
                    nph = 1; m_pend = mask; m_wait_cycles = 0; m_seen = 1'b0;
                end
                1: begin
                    m_seen = m_seen | full;
                    left = m_pend & ~done;
                    m_wait_cycles++;
                    if (left == 4'b0) nph = 2;
                    else if (TO_EN && m_wait_cycles == TO_CYC) begin
                        tc_ev = left; e_tp = 1'b1; nph = 2;
                    end
                    m_pend = left;
                end
                2: begin
                    inc = (m_seen || full) ? 1 : 0;
                    nph = 3;
                end
                default: nph = 0;
            endcase
            if (clear) begin e_ovr = 0; e_tc = '0; end
            e_ovr = (e_ovr + inc > 3) ? 3 : e_ovr + inc;
            e_tc = e_tc | tc_ev;
            e_adv = (nph == 2);
            if (nph == 2) e_seq = (e_seq + 1) % 16;
            m_phase = nph;
            e_fv = (nph == 1) ? m_pend : 4'b0;
            e_busy = (nph != 0);
        end
    end

    always @(negedge clk) begin
        chk("adv_read_enable", 32'(adv), 32'(e_adv));
        chk("frame_valid", 32'(fv), 32'(e_fv));
        chk("frame_seq", 32'(seq), 32'(e_seq[3:0]));
        chk("overrun_count", 32'(ovr), 32'(e_ovr[1:0]));
        chk("timeout_consumer", 32'(tc), 32'(e_tc));
        chk("timeout_pulse", 32'(tp), 32'(e_tp));
        chk("busy", 32'(busy), 32'(e_busy));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fv();
        int n = 0;
        tick();
        while (fv == 4'b0 && n < 50) begin tick(); n++; end
        chk("wait_frame_valid_bound", 32'(fv != 4'b0), 32'd1);
    endtask

    task automatic wait_adv(output int cycles);
        cycles = 1;
        tick();
        while (adv !== 1'b1 && cycles < 100) begin tick(); cycles++; end
        chk("wait_adv_bound", 32'(adv), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        chk("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic ovr_frame(input bit clr_at_adv);
        enable = 1'b1;
        wait_fv();
        enable = 1'b0;
        full = 1'b1;
        tick();
        full = 1'b0;
        done = 4'b0001;
        tick();
        done = 4'b0000;
        if (clr_at_adv) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) tick();
        chk("reset_adv", 32'(adv), 32'd0);
        chk("reset_seq", 32'(seq), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, enable dropped during WAIT.
        enable = 1'b1; ready = 1'b1; mask = 4'b1111;
        wait_fv();
        chk("basic_fv", 32'(fv), 32'hf);
        enable = 1'b0; done = 4'b1111;
        tick();
        done = 4'b0000;
        chk("basic_adv", 32'(adv), 32'd1);
        chk("basic_seq", 32'(seq), 32'd1);
        wait_idle();
        repeat (3) tick();
        chk("enable_low_holds_idle", 32'(busy), 32'd0);

        // Staggered done: consumer 0 at WAIT cycle 2, consumer 2 at cycle 7, consumer 1 not participating.
        enable = 1'b1; mask = 4'b0101;
        wait_fv();
        enable = 1'b0;
        tick();
        done = 4'b0011;
        tick();
        done = 4'b0000;
        chk("stagger_fv", 32'(fv), 32'h4);
        repeat (4) tick();
        done = 4'b0100;
        tick();
        done = 4'b0000;
        chk("stagger_adv", 32'(adv), 32'd1);
        chk("stagger_fv_low", 32'(fv), 32'd0);
        wait_idle();

        // Minimum frame period with done held high.
        enable = 1'b1; mask = 4'b1111; done = 4'b1111;
        wait_adv(c);
        wait_adv(c);
        enable = 1'b0;
        chk("frame_period", 32'(c), 32'd4);
        done = 4'b0000;
        wait_idle();

        if (TO_EN) begin
            enable = 1'b1; mask = 4'b1111;
            wait_fv();
            enable = 1'b0; done = 4'b0111;
            tick();
            done = 4'b0000;
            wait_adv(c);
            chk("timeout_latency", 32'(c), 32'd15);
            chk("timeout_pulse_lit", 32'(tp), 32'd1);
            chk("timeout_mask_lit", 32'(tc), 32'h8);
            wait_idle();
            // Final-cycle done honoured; clear coincides with the timeout.
            enable = 1'b1; mask = 4'b0110;
            wait_fv();
            enable = 1'b0;
            repeat (15) tick();
            done = 4'b0010; clear = 1'b1;
            tick();
            done = 4'b0000; clear = 1'b0;
            chk("timeout_clear_pulse", 32'(tp), 32'd1);
            chk("timeout_clear_mask", 32'(tc), 32'h4);
            wait_idle();
        end

        // Overrun counting and saturation.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovr_cleared", 32'(ovr), 32'd0);
        mask = 4'b0001;
        repeat (3) ovr_frame(1'b0);
        chk("ovr_three", 32'(ovr), 32'd3);
        repeat (2) ovr_frame(1'b0);
        chk("ovr_saturate", 32'(ovr), 32'd3);
        ovr_frame(1'b1);
        chk("ovr_clear_and_inc", 32'(ovr), 32'd1);

        // Reset during WAIT.
        enable = 1'b1; mask = 4'b1111;
        wait_fv();
        enable = 1'b0; rst_n = 1'b0;
        tick();
        chk("rst_mid_adv", 32'(adv), 32'd0);
        chk("rst_mid_fv", 32'(fv), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Sequence wrap with 17 frames at 4-bit width.
        enable = 1'b1; mask = 4'b0001; done = 4'b0001;
        for (int i = 0; i < 17; i++) wait_adv(c);
        enable = 1'b0;
        done = 4'b0000;
        wait_idle();
        chk("seq_wrap", 32'(seq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
